// File: rtl/emulador_hcsr04.sv
// Emulates an HC-SR04 ultrasonic sensor: validates the trigger width, waits the sensor delay,
// then drives an echo pulse whose width encodes the latched distance (or the out-of-range width).
module emulador_hcsr04 #(
  parameter int unsigned CICLOS_TRIGGER_MIN = 500,
  parameter int unsigned CICLOS_ATRASO      = 20000,
  parameter int unsigned CICLOS_POR_CM      = 2941,
  parameter int unsigned CICLOS_TIMEOUT     = 1900000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int unsigned MAX_TA = (CICLOS_TRIGGER_MIN > CICLOS_ATRASO) ?
                                   CICLOS_TRIGGER_MIN : CICLOS_ATRASO;
  localparam int unsigned MAX_C  = (MAX_TA > CICLOS_TIMEOUT) ? MAX_TA : CICLOS_TIMEOUT;
  localparam int unsigned CW_RAW = $clog2(MAX_C + 1);
  localparam int unsigned CW     = (CW_RAW < 21) ? 21 : CW_RAW;
  localparam int unsigned TW_RAW = $clog2(CICLOS_POR_CM + 1);
  localparam int unsigned TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int unsigned DW     = 9;

  typedef enum logic [3:0] {
    INICIAL      = 4'b0000,
    MEDE_TRIGGER = 4'b0001,
    ATRASO       = 4'b0010,
    GERA_ECHO    = 4'b0011,
    FIM          = 4'b0100
  } estado_t;

  estado_t         estado_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tick_q;
  logic [DW-1:0]   cm_q;
  logic [DW-1:0]   dist_q;
  logic            echo_q;
  logic            pronto_q;
  logic            dist_valida;

  // Distances the real sensor can report; anything else produces the out-of-range echo
  assign dist_valida = (dist_q >= DW'(2)) && (dist_q <= DW'(400));

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      cnt_q    <= '0;
      tick_q   <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      echo_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        INICIAL: begin
          if (trigger) begin
            estado_q <= MEDE_TRIGGER;
            cnt_q    <= CW'(1);
          end
        end

        MEDE_TRIGGER: begin
          if (trigger) begin
            if (cnt_q < CW'(CICLOS_TRIGGER_MIN)) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (cnt_q >= CW'(CICLOS_TRIGGER_MIN)) begin
            estado_q <= ATRASO;
            dist_q   <= distancia;
            cnt_q    <= '0;
          end else begin
            estado_q <= INICIAL;
            cnt_q    <= '0;
          end
        end

        ATRASO: begin
          if (cnt_q == CW'(CICLOS_ATRASO - 1)) begin
            estado_q <= GERA_ECHO;
            echo_q   <= 1'b1;
            cnt_q    <= '0;
            tick_q   <= '0;
            cm_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // In-range widths come from tick x cm counters; out-of-range uses the flat cycle counter
        GERA_ECHO: begin
          if (dist_valida) begin
            if (tick_q == TW'(CICLOS_POR_CM - 1)) begin
              tick_q <= '0;
              if (cm_q == dist_q - DW'(1)) begin
                estado_q <= FIM;
                echo_q   <= 1'b0;
                pronto_q <= 1'b1;
                cm_q     <= '0;
              end else begin
                cm_q <= cm_q + DW'(1);
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end else begin
            if (cnt_q == CW'(CICLOS_TIMEOUT - 1)) begin
              estado_q <= FIM;
              echo_q   <= 1'b0;
              pronto_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        FIM: begin
          estado_q <= INICIAL;
        end

        default: begin
          estado_q <= INICIAL;
          echo_q   <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign echo      = echo_q;
  assign pronto    = pronto_q;
  assign db_estado = estado_q;

endmodule

// File: doc/emulador_hcsr04.md
EMULADOR_HCSR04 -- requirements
Module: emulador_hcsr04

Interface
REQ-001 The block SHALL have parameter CICLOS_TRIGGER_MIN, default 500, giving the minimum valid trigger width (10 us at 50 MHz).
REQ-002 The block SHALL have parameter CICLOS_ATRASO, default 20000, giving the trigger-to-echo delay (400 us).
REQ-003 The block SHALL have parameter CICLOS_POR_CM, default 2941, giving echo cycles per cm (58.82 us).
REQ-004 The block SHALL have parameter CICLOS_TIMEOUT, default 1900000, giving the out-of-range echo width (38 ms).
REQ-005 The block SHALL have port clock, input, 1 bit: the single system clock, 50 MHz.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port trigger, input, 1 bit: sensor trigger from the measuring interface, synchronous to clock.
REQ-008 The block SHALL have port distancia, input, 9 bits: emulated distance in cm, unsigned binary.
REQ-009 The block SHALL have port echo, output, 1 bit: emulated sensor echo pulse, registered.
REQ-010 The block SHALL have port pronto, output, 1 bit: one-cycle pulse at end of each echo.
REQ-011 The block SHALL have port db_estado, output, 4 bits: current FSM state code.

Function
REQ-012 The FSM SHALL have states INICIAL=0000, MEDE_TRIGGER=0001, ATRASO=0010, GERA_ECHO=0011 and FIM=0100, and db_estado SHALL equal the current state code.
REQ-013 In INICIAL, trigger sampled 1 SHALL move the FSM to MEDE_TRIGGER with the trigger-width counter cleared to 1.
REQ-014 In MEDE_TRIGGER, the width counter SHALL increment while trigger=1 and saturate at CICLOS_TRIGGER_MIN.
REQ-015 In MEDE_TRIGGER, trigger sampled 0 SHALL lead to ATRASO if count >= CICLOS_TRIGGER_MIN, else to INICIAL with no echo.
REQ-016 On entry to ATRASO, distancia SHALL be latched, and later changes SHALL NOT affect the current echo.
REQ-017 ATRASO SHALL last exactly CICLOS_ATRASO cycles, then move to GERA_ECHO.
REQ-018 echo SHALL be 1 exactly while the FSM is in GERA_ECHO and 0 in every other state.
REQ-019 GERA_ECHO SHALL last D*CICLOS_POR_CM cycles for a latched value D in 2..400, counted by a tick counter 0..CICLOS_POR_CM-1 and a cm counter compared against D.
REQ-020 GERA_ECHO SHALL last CICLOS_TIMEOUT cycles when the latched D is 0, 1 or >400.
REQ-021 The cycle counters SHALL be wide enough for CICLOS_TIMEOUT (21 bits minimum) and SHALL NOT wrap within a phase.
REQ-022 At the end of GERA_ECHO the FSM SHALL enter FIM, where pronto=1 for exactly one cycle, then return to INICIAL.
REQ-023 Trigger activity in ATRASO, GERA_ECHO or FIM SHALL be ignored, and no queued measurement SHALL result.
REQ-024 A trigger held high at return to INICIAL SHALL start a new MEDE_TRIGGER, and its width SHALL be counted from that cycle.

Reset
REQ-025 reset=1 at a clock edge SHALL force state INICIAL, echo=0, pronto=0, db_estado=0000 and all counters to 0 on that edge, from any state.
REQ-026 Reset mid-echo SHALL drop echo on the same edge, and no pronto SHALL be produced for the aborted measurement.

Verification
REQ-027 The bench SHALL check: distancia=100, trigger high for 500 cycles -> echo rises 20000 cycles after trigger falls, stays high 294100 cycles (5882 us), pronto pulses once.
REQ-028 The bench SHALL check: distancia=74 -> echo width 217634 cycles (4352.68 us), within which the interface rounds to 74 cm.
REQ-029 The bench SHALL check: trigger high for 499 cycles -> no echo, and db_estado returns to 0000 one cycle after trigger falls.
REQ-030 The bench SHALL check: distancia=0 and distancia=450 -> echo width 1900000 cycles each.
REQ-031 The bench SHALL check: a second 10 us trigger during echo and a distancia change during ATRASO -> echo width unchanged, only one pronto.
REQ-032 The bench SHALL check: reset asserted 1000 cycles into echo -> echo=0 and db_estado=0000 after that edge, no pronto, and a following trigger works normally.
